// File: rtl/vectorized_pe_stream_pkg.sv
// Shared definitions for the vectorized PE stream: opcode encoding and default geometry.
package vectorized_pe_stream_pkg;

    localparam int SIMD_DEGREE_DEF = 16;
    localparam int DWIDTH_DEF      = 32;

    typedef enum logic [2:0] {
        PE_ADD  = 3'd0,
        PE_SUB  = 3'd1,
        PE_MUL  = 3'd2,
        PE_MAX  = 3'd3,
        PE_MIN  = 3'd4,
        PE_ACC  = 3'd5,
        PE_PASS = 3'd6,
        PE_RSVD = 3'd7
    } pe_op_e;

endpackage

// File: rtl/vectorized_pe_stream_if.sv
// Two joined operand streams plus the result stream of the vectorized PE.
interface vectorized_pe_stream_if #(
   parameter int SIMD_DEGREE = vectorized_pe_stream_pkg::SIMD_DEGREE_DEF,
   parameter int DWIDTH      = vectorized_pe_stream_pkg::DWIDTH_DEF
);
   logic [2:0]                    op;
   logic [SIMD_DEGREE-1:0]        lane_mask;
   logic [SIMD_DEGREE*DWIDTH-1:0] s1_tdata;
   logic [SIMD_DEGREE*DWIDTH-1:0] s2_tdata;
   logic                          s1_tvalid;
   logic                          s2_tvalid;
   logic                          s1_tlast;
   logic                          s1_tready;
   logic                          s2_tready;
   logic [SIMD_DEGREE*DWIDTH-1:0] m_tdata;
   logic                          m_tvalid;
   logic                          m_tlast;
   logic                          m_tready;

   modport master (
      output op, lane_mask, s1_tdata, s2_tdata, s1_tvalid, s2_tvalid, s1_tlast, m_tready,
      input  s1_tready, s2_tready, m_tdata, m_tvalid, m_tlast
   );

   modport slave (
      input  op, lane_mask, s1_tdata, s2_tdata, s1_tvalid, s2_tvalid, s1_tlast, m_tready,
      output s1_tready, s2_tready, m_tdata, m_tvalid, m_tlast
   );
endinterface

// File: rtl/pe_lane.sv
// One SIMD lane: signed op logic, per-lane accumulator and a LATENCY-deep result pipeline.
module pe_lane
   import vectorized_pe_stream_pkg::*;
#(
   parameter int DWIDTH  = DWIDTH_DEF,
   parameter int LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fire,
   input  logic              en,
   input  logic              last,
   input  pe_op_e            op,
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   output logic [DWIDTH-1:0] result
);
   logic signed [DWIDTH-1:0] sa, sb, acc_reg, acc_sum, res_next;
   logic [DWIDTH-1:0]        pipe_reg [LATENCY];

   assign sa      = $signed(a);
   assign sb      = $signed(b);
   assign acc_sum = acc_reg + sa;

   always_comb begin
      res_next = '0;
      if (en) begin
         case (op)
            PE_ADD:  res_next = sa + sb;
            PE_SUB:  res_next = sa - sb;
            PE_MUL:  res_next = sa * sb;
            PE_MAX:  res_next = (sa > sb) ? sa : sb;
            PE_MIN:  res_next = (sa < sb) ? sa : sb;
            PE_ACC:  res_next = acc_sum;
            PE_PASS: res_next = sa;
            default: res_next = '0;
         endcase
      end
   end

   // Other ops leave the accumulator alone so a packet can resume after an op switch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg <= '0;
      end else if (fire && en && op == PE_ACC) begin
         acc_reg <= last ? '0 : acc_sum;
      end
   end

   always_ff @(posedge clk) begin
      pipe_reg[0] <= res_next;
      for (int k = 1; k < LATENCY; k++) begin
         pipe_reg[k] <= pipe_reg[k-1];
      end
   end

   assign result = pipe_reg[LATENCY-1];
endmodule

// File: rtl/vectorized_pe_stream.sv
// Vectorized PE: joins two operand streams, runs a non-stalling lane pipeline and buffers
// results in a credit-protected FIFO with a registered output stage.
module vectorized_pe_stream
   import vectorized_pe_stream_pkg::*;
#(
   parameter int SIMD_DEGREE = SIMD_DEGREE_DEF,
   parameter int DWIDTH      = DWIDTH_DEF,
   parameter int LATENCY     = 4,
   parameter int FIFO_DEPTH  = 8
) (
   input logic                    clk,
   input logic                    rst,
   vectorized_pe_stream_if.slave  bus
);
   localparam int VW = SIMD_DEGREE * DWIDTH;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   if (LATENCY < 1 || FIFO_DEPTH < LATENCY + 2) begin : g_bad_params
      $error("vectorized_pe_stream: need LATENCY >= 1 and FIFO_DEPTH >= LATENCY+2");
   end

   pe_op_e          op_e;
   logic            credit_ok, fire, produces, push, pop, load;
   logic [CW-1:0]   in_flight_reg, mem_count_reg;
   logic [CW:0]     occupancy;
   logic [LATENCY-1:0] wr_pipe_reg, last_pipe_reg;
   logic [VW-1:0]   lane_result;
   logic [VW:0]     mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic            m_valid_reg, m_last_reg;
   logic [VW-1:0]   m_data_reg;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign op_e = pe_op_e'(bus.op);

   // Every beat that will eventually be written reserves a slot before it fires.
   assign occupancy = (CW+1)'(in_flight_reg) + (CW+1)'(mem_count_reg) + (CW+1)'(m_valid_reg);
   assign credit_ok = ~rst & (occupancy < (CW+1)'(FIFO_DEPTH));
   assign fire      = bus.s1_tvalid & bus.s2_tvalid & credit_ok;
   assign produces  = (op_e != PE_ACC) | bus.s1_tlast;

   assign bus.s1_tready = bus.s2_tvalid & credit_ok;
   assign bus.s2_tready = bus.s1_tvalid & credit_ok;

   for (genvar gi = 0; gi < SIMD_DEGREE; gi++) begin : g_lane
      pe_lane #(
         .DWIDTH  (DWIDTH),
         .LATENCY (LATENCY)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .fire   (fire),
         .en     (bus.lane_mask[gi]),
         .last   (bus.s1_tlast),
         .op     (op_e),
         .a      (bus.s1_tdata[gi*DWIDTH +: DWIDTH]),
         .b      (bus.s2_tdata[gi*DWIDTH +: DWIDTH]),
         .result (lane_result[gi*DWIDTH +: DWIDTH])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_pipe_reg   <= '0;
         last_pipe_reg <= '0;
         in_flight_reg <= '0;
      end else begin
         wr_pipe_reg[0]   <= fire & produces;
         last_pipe_reg[0] <= bus.s1_tlast;
         for (int k = 1; k < LATENCY; k++) begin
            wr_pipe_reg[k]   <= wr_pipe_reg[k-1];
            last_pipe_reg[k] <= last_pipe_reg[k-1];
         end
         in_flight_reg <= in_flight_reg + CW'(fire & produces) - CW'(wr_pipe_reg[LATENCY-1]);
      end
   end

   assign push = wr_pipe_reg[LATENCY-1];
   assign pop  = m_valid_reg & bus.m_tready;
   assign load = (mem_count_reg != '0) & (~m_valid_reg | pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {last_pipe_reg[LATENCY-1], lane_result};
      end
   end

   // Output register is refilled from the array whenever it empties or is being drained.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         mem_count_reg <= '0;
         m_valid_reg   <= 1'b0;
         m_last_reg    <= 1'b0;
         m_data_reg    <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         mem_count_reg <= mem_count_reg + CW'(push) - CW'(load);
         if (load) begin
            {m_last_reg, m_data_reg} <= mem[rd_ptr_reg];
            rd_ptr_reg  <= ptr_inc(rd_ptr_reg);
            m_valid_reg <= 1'b1;
         end else if (pop) begin
            m_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.m_tvalid = m_valid_reg;
   assign bus.m_tlast  = m_last_reg;
   assign bus.m_tdata  = m_data_reg;
endmodule

// File: tb/tb_vectorized_pe_stream.sv
// Directed + scoreboard bench for vectorized_pe_stream (16 lanes x 32 bits, LATENCY 4, depth 8).
module tb_vectorized_pe_stream;
    import vectorized_pe_stream_pkg::*;

    localparam int SD  = 16;
    localparam int DW  = 32;
    localparam int LAT = 4;
    localparam int FD  = 8;
    localparam int VW  = SD * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vectorized_pe_stream_if #(.SIMD_DEGREE(SD), .DWIDTH(DW)) bus ();

    vectorized_pe_stream #(
        .SIMD_DEGREE (SD),
        .DWIDTH      (DW),
        .LATENCY     (LAT),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int fire_cnt = 0;
    int out_cnt  = 0;
    logic [VW:0] exp_q [$];
    logic signed [DW-1:0] model_acc [SD];

    task automatic check_vec(input string tag, input logic [VW:0] obs, input logic [VW:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted beat, using the raw opcode values.
    task automatic model_beat();
        logic [VW-1:0] r;
        logic signed [DW-1:0] a, b, v;
        r = '0;
        for (int i = 0; i < SD; i++) begin
            a = bus.s1_tdata[i*DW +: DW];
            b = bus.s2_tdata[i*DW +: DW];
            v = '0;
            if (bus.lane_mask[i]) begin
                case (bus.op)
                    3'd0: v = a + b;
                    3'd1: v = a - b;
                    3'd2: v = a * b;
                    3'd3: v = (a > b) ? a : b;
                    3'd4: v = (a < b) ? a : b;
                    3'd5: begin
                        v = model_acc[i] + a;
                        model_acc[i] = bus.s1_tlast ? '0 : v;
                    end
                    3'd6: v = a;
                    default: v = '0;
                endcase
            end
            r[i*DW +: DW] = v;
        end
        if (bus.op != 3'd5 || bus.s1_tlast) exp_q.push_back({bus.s1_tlast, r});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.s1_tvalid && bus.s2_tvalid && bus.s1_tready) begin
                fire_cnt++;
                model_beat();
            end
            if (bus.m_tvalid && bus.m_tready) begin
                logic [VW:0] e;
                out_cnt++;
                check_int("output_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_vec("output_beat", {bus.m_tlast, bus.m_tdata}, e);
                    $display("out #%0d last=%0d lane0=%0d lane15=%0d", out_cnt, bus.m_tlast,
                             $signed(bus.m_tdata[DW-1:0]), $signed(bus.m_tdata[VW-1 -: DW]));
                end
            end
        end
    end

    task automatic set_beat(input pe_op_e o, input logic [SD-1:0] m, input int a, input int b,
                            input int step, input logic last);
        bus.op        = o;
        bus.lane_mask = m;
        bus.s1_tlast  = last;
        for (int i = 0; i < SD; i++) begin
            bus.s1_tdata[i*DW +: DW] = DW'(a + i * step);
            bus.s2_tdata[i*DW +: DW] = DW'(b - i * step);
        end
        bus.s1_tvalid = 1'b1;
        bus.s2_tvalid = 1'b1;
    endtask

    task automatic idle();
        bus.s1_tvalid = 1'b0;
        bus.s2_tvalid = 1'b0;
        bus.s1_tlast  = 1'b0;
    endtask

    // Presents a beat and returns once it has fired; waited counts stall cycles.
    task automatic send(input pe_op_e o, input logic [SD-1:0] m, input int a, input int b,
                        input int step, input logic last, output int waited);
        set_beat(o, m, a, b, step, last);
        waited = 0;
        @(negedge clk);
        while (!bus.s1_tready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.s1_tready) check_int("send_accept", 32'(bus.s1_tready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check_int(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w, tw, cyc, acc_o, f0, o0, accepted;
        foreach (model_acc[i]) model_acc[i] = '0;
        rst           = 1'b1;
        bus.op        = PE_ADD;
        bus.lane_mask = '1;
        bus.s1_tdata  = '0;
        bus.s2_tdata  = '0;
        bus.s1_tlast  = 1'b0;
        bus.s1_tvalid = 1'b1;
        bus.s2_tvalid = 1'b1;
        bus.m_tready  = 1'b0;
        repeat (3) @(negedge clk);
        check_int("reset_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check_int("reset_m_tlast", 32'(bus.m_tlast), 32'd0);
        check_vec("reset_m_tdata", {1'b0, bus.m_tdata}, '0);
        check_int("reset_s1_tready", 32'(bus.s1_tready), 32'd0);
        check_int("reset_s2_tready", 32'(bus.s2_tready), 32'd0);
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        bus.m_tready = 1'b1;
        repeat (2) @(posedge clk); #1;

        // ADD 5 + -3 with first-output latency
        send(PE_ADD, '1, 5, -3, 0, 1'b1, w);
        idle();
        cyc = 0;
        while (!bus.m_tvalid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_int("add_latency", 32'(cyc), 32'(LAT + 1));
        drain("add_drain");

        // Op mix, back-to-back, wrap cases and lane-varying data
        tw = 0;
        send(PE_ADD,  '1, 5, -3, 0, 1'b0, w);          tw += w;
        send(PE_SUB,  '1, 5, -3, 1, 1'b0, w);          tw += w;
        send(PE_MUL,  '1, 32'h10000, 32'h10000, 0, 1'b0, w); tw += w;
        send(PE_MUL,  '1, -4, 6, 1, 1'b1, w);          tw += w;
        send(PE_MAX,  '1, -7, 2, 1, 1'b0, w);          tw += w;
        send(PE_MIN,  '1, -7, 2, 1, 1'b0, w);          tw += w;
        send(PE_PASS, '1, -123, 9, 2, 1'b1, w);        tw += w;
        send(PE_RSVD, '1, 11, 22, 1, 1'b0, w);         tw += w;
        send(PE_ADD,  '1, 32'h7fffffff, 1, 0, 1'b1, w); tw += w;
        idle();
        check_int("throughput_stalls", 32'(tw), 32'd0);
        drain("ops_drain");

        // ACC packet 1..4, then a fresh packet, then op switch mid-packet
        acc_o = out_cnt;
        send(PE_ACC, '1, 1, 0, 0, 1'b0, w);
        send(PE_ACC, '1, 2, 0, 0, 1'b0, w);
        send(PE_ACC, '1, 3, 0, 0, 1'b0, w);
        send(PE_ACC, '1, 4, 0, 0, 1'b1, w);
        idle();
        drain("acc_drain");
        check_int("acc_output_count", 32'(out_cnt - acc_o), 32'd1);
        send(PE_ACC, '1, 7, 0, 1, 1'b1, w);
        send(PE_ACC, '1, 2, 0, 1, 1'b0, w);
        send(PE_ADD, '1, 1, 1, 0, 1'b0, w);
        send(PE_ACC, '1, 3, 0, 0, 1'b1, w);
        idle();
        drain("acc_switch_drain");

        // Lane mask on MUL and on the accumulator
        send(PE_MUL, 16'h00FF, 3, 7, 0, 1'b1, w);
        send(PE_ACC, 16'h0F0F, 5, 0, 0, 1'b0, w);
        send(PE_ACC, 16'hFFFF, 1, 0, 0, 1'b1, w);
        idle();
        drain("mask_drain");

        // Join: s2 missing must block the beat
        set_beat(PE_SUB, '1, 40, 2, 1, 1'b1);
        bus.s2_tvalid = 1'b0;
        f0 = fire_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_int("join_s1_tready_low", 32'(bus.s1_tready), 32'd0);
        end
        check_int("join_s2_tready", 32'(bus.s2_tready), 32'd1);
        check_int("join_no_fire", 32'(fire_cnt - f0), 32'd0);
        @(posedge clk); #1;
        bus.s2_tvalid = 1'b1;
        @(negedge clk);
        check_int("join_s1_tready_high", 32'(bus.s1_tready), 32'd1);
        @(posedge clk); #1;
        idle();
        drain("join_drain");
        check_int("join_single_fire", 32'(fire_cnt - f0), 32'd1);

        // Backpressure: only FIFO_DEPTH beats may be accepted, output must hold
        bus.m_tready = 1'b0;
        accepted = 0;
        o0 = out_cnt;
        for (int c = 0; c < 40 && accepted < 20; c++) begin
            set_beat(PE_ADD, '1, 1000 + accepted, accepted, 1, 1'(accepted % 3 == 2));
            @(negedge clk);
            if (bus.s1_tready) accepted++;
            if (bus.m_tvalid && exp_q.size() != 0)
                check_vec("hold_stable", {bus.m_tlast, bus.m_tdata}, exp_q[0]);
            @(posedge clk); #1;
        end
        check_int("bp_accepted", 32'(accepted), 32'(FD));
        @(negedge clk);
        check_int("bp_s1_tready", 32'(bus.s1_tready), 32'd0);
        check_int("bp_s2_tready", 32'(bus.s2_tready), 32'd0);
        @(posedge clk); #1;
        idle();
        bus.m_tready = 1'b1;
        drain("bp_drain");
        check_int("bp_outputs", 32'(out_cnt - o0), 32'(FD));

        // Random ops, masks and m_tready toggling
        accepted = 0;
        for (int c = 0; c < 400 && accepted < 40; c++) begin
            set_beat(pe_op_e'($urandom_range(0, 7)), SD'($urandom), int'($urandom),
                     int'($urandom), int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)));
            bus.m_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.s1_tready) accepted++;
            @(posedge clk); #1;
        end
        idle();
        bus.m_tready = 1'b1;
        check_int("rand_accepted", 32'(accepted), 32'd40);
        drain("rand_drain");

        // Reset with 3 beats in flight and 2 in the FIFO
        bus.m_tready = 1'b0;
        send(PE_ACC, '1, 9, 0, 0, 1'b0, w);
        for (int i = 0; i < 5; i++) send(PE_ADD, '1, 50 + i, 1, 1, 1'b0, w);
        idle();
        @(posedge clk); #1;
        check_int("pre_reset_m_tvalid", 32'(bus.m_tvalid), 32'd1);
        #1;
        rst = 1'b1;
        bus.s1_tvalid = 1'b1;
        bus.s2_tvalid = 1'b1;
        #1;
        check_int("midrst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        check_int("midrst_m_tlast", 32'(bus.m_tlast), 32'd0);
        check_vec("midrst_m_tdata", {1'b0, bus.m_tdata}, '0);
        check_int("midrst_s1_tready", 32'(bus.s1_tready), 32'd0);
        exp_q.delete();
        foreach (model_acc[i]) model_acc[i] = '0;
        repeat (2) @(posedge clk); #1;
        idle();
        rst = 1'b0;
        bus.m_tready = 1'b1;
        o0 = out_cnt;
        repeat (20) @(negedge clk);
        check_int("no_stale_output", 32'(out_cnt - o0), 32'd0);
        @(posedge clk); #1;
        send(PE_ACC, '1, 5, 0, 0, 1'b1, w);
        idle();
        drain("post_reset_drain");
        check_int("post_reset_outputs", 32'(out_cnt - o0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
